// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - peripheral bus interface used by pwm_capture
interface bus_protocol_if;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  addr,
        input  wen,
        input  ren,
        input  wdata,
        output rdata,
        output error,
        output request_stall
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - multi-channel PWM input capture (period and high time)
module pwm_capture #(
    parameter int NUM_CHANNELS = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_CHANNELS-1:0] pwm_in,
    bus_protocol_if.peripheral_vital busif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [31:0]          MAP_END = 32'(NUM_CHANNELS * 16);

    // Input synchronizer (two flops) plus one flop of history for edge detection
    logic [NUM_CHANNELS-1:0] sync1_q, sync2_q, edge_q;
    logic [NUM_CHANNELS-1:0] rise, fall;

    // Per-channel measurement and register state
    logic [1:0]           state_q     [NUM_CHANNELS];
    logic [1:0]           state_d     [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q       [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d       [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] hi_shadow_q [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] hi_shadow_d [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] period_q    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] period_d    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] high_q      [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] high_d      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] en_q, en_d;
    logic [NUM_CHANNELS-1:0] valid_q, valid_d;
    logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;

    // Bus decode
    logic [27:0] ch_idx;
    logic [1:0]  reg_idx;
    logic        unmapped;
    logic        ro_write;
    logic        bus_err;
    logic        wr_ok;
    logic [31:0] rdata_c;
    logic        unused_wdata;

    assign rise = sync2_q & ~edge_q;
    assign fall = ~sync2_q & edge_q;

    assign ch_idx   = busif.addr[31:4];
    assign reg_idx  = busif.addr[3:2];
    assign unmapped = (busif.addr >= MAP_END) || (busif.addr[1:0] != 2'b00);
    assign ro_write = busif.wen && ((reg_idx == 2'd1) || (reg_idx == 2'd2));
    assign bus_err  = (busif.wen || busif.ren) && (unmapped || ro_write);
    assign wr_ok    = busif.wen && !bus_err;

    assign busif.error         = bus_err;
    assign busif.rdata         = rdata_c;
    assign busif.request_stall = 1'b0;
    assign unused_wdata        = ^busif.wdata[31:2];

    // Combinational read mux; zero unless a mapped register is being read
    always_comb begin
        rdata_c = '0;
        if (busif.ren && !unmapped) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (ch_idx == 28'(i)) begin
                    case (reg_idx)
                        2'd0:    rdata_c = {31'd0, en_q[i]};
                        2'd1:    rdata_c = 32'(period_q[i]);
                        2'd2:    rdata_c = 32'(high_q[i]);
                        default: rdata_c = {30'd0, ovf_q[i], valid_q[i]};
                    endcase
                end
            end
        end
    end

    // Per-channel FSM, counter and register next-state, including bus writes
    logic ctrl_wr, stat_wr, clr, valid_set, ovf_set;
    always_comb begin
        ctrl_wr   = 1'b0;
        stat_wr   = 1'b0;
        clr       = 1'b0;
        valid_set = 1'b0;
        ovf_set   = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            hi_shadow_d[i] = hi_shadow_q[i];
            period_d[i]    = period_q[i];
            high_d[i]      = high_q[i];
            valid_set      = 1'b0;
            ovf_set        = 1'b0;

            ctrl_wr = wr_ok && (ch_idx == 28'(i)) && (reg_idx == 2'd0);
            stat_wr = wr_ok && (ch_idx == 28'(i)) && (reg_idx == 2'd3);
            clr     = ctrl_wr && busif.wdata[1];
            en_d[i] = ctrl_wr ? busif.wdata[0] : en_q[i];

            case (state_q[i])
                ST_IDLE: begin
                    cnt_d[i] = '0;
                    if (en_q[i]) state_d[i] = ST_ARM;
                end
                ST_ARM: begin
                    cnt_d[i] = '0;
                    if (!en_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (rise[i]) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!en_q[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        ovf_set    = 1'b1;
                        state_d[i] = ST_ARM;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        if (fall[i]) begin
                            hi_shadow_d[i] = cnt_q[i];
                            state_d[i]     = ST_LOW;
                        end
                    end
                end
                default: begin
                    if (!en_q[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        ovf_set    = 1'b1;
                        state_d[i] = ST_ARM;
                        cnt_d[i]   = '0;
                    end else if (rise[i]) begin
                        // Period closes: publish period and high time together
                        period_d[i] = cnt_q[i];
                        high_d[i]   = hi_shadow_q[i];
                        valid_set   = 1'b1;
                        cnt_d[i]    = CNT_ONE;
                        state_d[i]  = ST_HIGH;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            endcase

            // Hardware set beats a same-cycle W1C
            valid_d[i] = valid_set || (valid_q[i] && !(stat_wr && busif.wdata[0]));
            ovf_d[i]   = ovf_set   || (ovf_q[i]   && !(stat_wr && busif.wdata[1]));

            // CLR beats everything, including a same-cycle capture
            if (clr) begin
                period_d[i]    = '0;
                high_d[i]      = '0;
                hi_shadow_d[i] = '0;
                cnt_d[i]       = '0;
                valid_d[i]     = 1'b0;
                ovf_d[i]       = 1'b0;
                state_d[i]     = busif.wdata[0] ? ST_ARM : ST_IDLE;
            end
        end
    end

    // Synchronizer and edge-history flops
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    // Channel state registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]     <= ST_IDLE;
                cnt_q[i]       <= '0;
                hi_shadow_q[i] <= '0;
                period_q[i]    <= '0;
                high_q[i]      <= '0;
            end
            en_q    <= '0;
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                hi_shadow_q[i] <= hi_shadow_d[i];
                period_q[i]    <= period_d[i];
                high_q[i]      <= high_d[i];
            end
            en_q    <= en_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam int NCH = 2;
    localparam int CW  = 8;

    logic           CLK = 1'b0;
    logic           nRST;
    logic [NCH-1:0] pwm_in;

    bus_protocol_if bus();

    pwm_capture #(
        .NUM_CHANNELS (NCH),
        .CNT_WIDTH    (CW)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .pwm_in (pwm_in),
        .busif  (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Pending waveform settings (mode 0 = low, 1 = PWM, 2 = constant high);
    // the generator adopts them only at a period boundary
    int pw_mode [NCH] = '{0, 0};
    int pw_per  [NCH] = '{1, 1};
    int pw_hi   [NCH] = '{0, 0};
    int cur_mode[NCH] = '{0, 0};
    int cur_per [NCH] = '{1, 1};
    int cur_hi  [NCH] = '{0, 0};
    int ph      [NCH] = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge CLK);
        bus.addr = a;
        bus.ren  = 1'b1;
        #1;
        d = bus.rdata;
        e = bus.error;
        bus.ren = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic e);
        @(negedge CLK);
        bus.addr  = a;
        bus.wdata = d;
        bus.wen   = 1'b1;
        #1;
        e = bus.error;
        @(posedge CLK);
        #1;
        bus.wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        bus_read(a, d, e);
        check_eq(tag, d, exp);
        check_eq({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic wait_bits(input string tag, input logic [31:0] a, input logic [31:0] mask,
                             input int budget);
        logic [31:0] d;
        logic        e;
        logic        seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            bus_read(a, d, e);
            if ((d & mask) == mask) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    // PWM pin generator, updated just after each rising clock edge
    initial begin
        pwm_in = '0;
        forever begin
            @(posedge CLK);
            #2;
            for (int c = 0; c < NCH; c++) begin
                if (cur_mode[c] != 1 || ph[c] >= cur_per[c] - 1) begin
                    cur_mode[c] = pw_mode[c];
                    cur_per[c]  = pw_per[c];
                    cur_hi[c]   = pw_hi[c];
                    ph[c]       = 0;
                end else begin
                    ph[c]++;
                end
                pwm_in[c] = (cur_mode[c] == 2) || (cur_mode[c] == 1 && ph[c] < cur_hi[c]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d, d2, h;
        logic        e;
        logic        ok;

        nRST      = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        // Reset values and bus error decode
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++)
                rd_chk($sformatf("rst_c%0d_r%0d", c, r), 32'(c * 16 + r * 4), 32'd0);
        bus_read(32'h20, d, e);
        check_eq("unmapped_err", {31'd0, e}, 32'd1);
        check_eq("unmapped_rdata", d, 32'd0);
        check_eq("stall", {31'd0, bus.request_stall}, 32'd0);

        // ch0 at 100/25
        pw_per[0] = 100; pw_hi[0] = 25; pw_mode[0] = 1;
        bus_write(32'h0, 32'h1, e);
        check_eq("en_wr_err", {31'd0, e}, 32'd0);
        wait_bits("cap1_wait", 32'hC, 32'h1, 400);
        rd_chk("cap1_period", 32'h4, 32'd100);
        rd_chk("cap1_high",   32'h8, 32'd25);
        rd_chk("cap1_status", 32'hC, 32'h1);
        bus_read(32'h5, d, e);
        check_eq("misalign_err", {31'd0, e}, 32'd1);
        check_eq("misalign_rdata", d, 32'd0);

        // Switch to 40/30; every coherent snapshot must be a legal pair
        pw_per[0] = 40; pw_hi[0] = 30;
        for (int k = 0; k < 30; k++) begin
            bus_read(32'h4, d, e);
            bus_read(32'h8, h, e);
            bus_read(32'h4, d2, e);
            if (d == d2) begin
                ok = ((d == 32'd100) && (h == 32'd25)) || ((d == 32'd40) && (h == 32'd30));
                check_eq("pair_coherent", {31'd0, ok}, 32'd1);
            end
            repeat (10) @(negedge CLK);
        end
        rd_chk("cap2_period", 32'h4, 32'd40);
        rd_chk("cap2_high",   32'h8, 32'd30);

        // Constant-high input overflows the 8-bit counter
        pw_mode[0] = 2;
        wait_bits("ovf_wait", 32'hC, 32'h2, 400);
        rd_chk("ovf_period_kept", 32'h4, 32'd40);
        rd_chk("ovf_high_kept",   32'h8, 32'd30);
        bus_write(32'hC, 32'h2, e);
        rd_chk("ovf_w1c", 32'hC, 32'h1);
        bus_write(32'hC, 32'h0, e);
        rd_chk("w1c_zero_noop", 32'hC, 32'h1);

        // Errored writes change nothing; CLR zeroes the channel
        bus_write(32'h4, 32'd5, e);
        check_eq("ro_period_err", {31'd0, e}, 32'd1);
        rd_chk("ro_period_kept", 32'h4, 32'd40);
        bus_write(32'h8, 32'd5, e);
        check_eq("ro_high_err", {31'd0, e}, 32'd1);
        bus_write(32'h2, 32'h0, e);
        check_eq("misalign_wr_err", {31'd0, e}, 32'd1);
        rd_chk("misalign_wr_kept", 32'h0, 32'h1);
        bus_write(32'h0, 32'h3, e);
        check_eq("clr_err", {31'd0, e}, 32'd0);
        rd_chk("clr_period", 32'h4, 32'd0);
        rd_chk("clr_high",   32'h8, 32'd0);
        rd_chk("clr_status", 32'hC, 32'h0);
        rd_chk("clr_ctrl",   32'h0, 32'h1);

        // EN dropped in the high phase, then re-enabled on a new waveform
        pw_per[0] = 100; pw_hi[0] = 25; pw_mode[0] = 1;
        wait_bits("cap3_wait", 32'hC, 32'h1, 400);
        bus_write(32'h0, 32'h0, e);
        bus_write(32'hC, 32'h1, e);
        pw_per[0] = 60; pw_hi[0] = 20;
        repeat (150) @(negedge CLK);
        rd_chk("dis_period_kept", 32'h4, 32'd100);
        rd_chk("dis_status",      32'hC, 32'h0);
        bus_write(32'h0, 32'h1, e);
        wait_bits("reen_wait", 32'hC, 32'h1, 400);
        rd_chk("reen_period", 32'h4, 32'd60);
        rd_chk("reen_high",   32'h8, 32'd20);

        // Both channels running, async reset mid-capture
        pw_per[0] = 100; pw_hi[0] = 25;
        pw_per[1] = 64;  pw_hi[1] = 63; pw_mode[1] = 1;
        bus_write(32'h10, 32'h1, e);
        wait_bits("ch1_pre_wait", 32'h1C, 32'h1, 400);
        repeat (20) @(negedge CLK);
        @(negedge CLK);
        bus.addr = 32'h14;
        bus.ren  = 1'b1;
        #1;
        check_eq("pre_rst_ch1_period", bus.rdata, 32'd64);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("rst_async_ch1_period", bus.rdata, 32'd0);
        bus.addr = 32'h4;
        #1;
        check_eq("rst_async_ch0_period", bus.rdata, 32'd0);
        bus.addr = 32'h0;
        #1;
        check_eq("rst_async_ch0_ctrl", bus.rdata, 32'd0);
        bus.ren = 1'b0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        bus_write(32'h0,  32'h1, e);
        bus_write(32'h10, 32'h1, e);
        wait_bits("post_ch0_wait", 32'hC,  32'h1, 400);
        wait_bits("post_ch1_wait", 32'h1C, 32'h1, 400);
        rd_chk("post_ch0_period", 32'h4,  32'd100);
        rd_chk("post_ch0_high",   32'h8,  32'd25);
        rd_chk("post_ch1_period", 32'h14, 32'd64);
        rd_chk("post_ch1_high",   32'h18, 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
